// File: rtl/axi_wr_slave_if.sv
// AXI write-channel bundle (AW, W and B) between a master agent and axi_wr_slave.
// The slave modport is the responder's view. The master modport is the driver's view.
interface axi_wr_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8
);

  // Write address channel
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  // Write data channel
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  // Write response channel
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/axi_wr_slave.sv
// AXI write slave. It accepts one AW/W burst at a time, turns every accepted beat
// into a registered word write on a simple memory port, and returns one B response
// per burst.
// Optional feature: define AXI_WR_WLAST_CHK_EN to flag wlast placement errors as
// SLVERR. When that macro is left undefined, wlast is ignored.
module axi_wr_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  axi_wr_slave_if.slave                bus,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]        mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]      mem_wstrb_o
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(STRB_W);
  localparam int IDX_W   = $clog2(MEM_DEPTH);
  // Number of byte-address bits that map onto the memory. Any bit set above
  // this range means the address falls outside the memory.
  localparam int BYTE_AW = IDX_W + OFF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;

  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            beat_q, beat_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  cfgErr_q, cfgErr_d;
  logic                  slvErr_q, slvErr_d;
  logic                  decErr_q, decErr_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  memWe_q, memWe_d;
  logic [IDX_W-1:0]      memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
  logic [STRB_W-1:0]     memWstrb_q, memWstrb_d;

  logic                  awHs, wHs, bHs;
  logic                  lastBeat, widErr, outOfRange, cfgErrAw;
  logic                  wlastMis, wlastKill;
  logic [ADDR_WIDTH-1:0] sizeBytes, alignedAddr, incrAddr, wrapMask, nextAddr;

  assign awHs       = bus.awvalid & awready_q;
  assign wHs        = bus.wvalid & wready_q;
  assign bHs        = bus.bready & bvalid_q;
  assign lastBeat   = (beat_q == len_q);
  assign widErr     = (bus.wid != id_q);
  assign outOfRange = ((addr_q >> BYTE_AW) != '0);

  // A burst is unusable as a whole in three cases: it uses the reserved burst
  // type, its beat is wider than the bus, or it is a WRAP burst with an illegal
  // length.
  assign cfgErrAw = (bus.awburst == 2'b11)
                  | (int'(bus.awsize) > OFF_W)
                  | ((bus.awburst == 2'b10) &&
                     !(bus.awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

`ifdef AXI_WR_WLAST_CHK_EN
  logic wlastBad_q, wlastBad_d;

  // A beat is mismatched if wlast disagrees with the beat count. Once one beat
  // is mismatched, the rest of the burst is treated as corrupt.
  assign wlastMis  = wHs & (bus.wlast != lastBeat);
  assign wlastKill = wlastBad_q | wlastMis;

  always_comb begin
    wlastBad_d = wlastBad_q;
    if (awHs) begin
      wlastBad_d = 1'b0;
    end else if (wlastMis) begin
      wlastBad_d = 1'b1;
    end
  end

  // Sticky flag recording a wlast mismatch during the current burst
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wlastBad_q <= 1'b0;
    end else begin
      wlastBad_q <= wlastBad_d;
    end
  end
`else
  logic unusedWlast;

  assign unusedWlast = bus.wlast;
  assign wlastMis    = 1'b0;
  assign wlastKill   = 1'b0;
`endif

  // Compute the burst address that follows the current beat
  always_comb begin
    sizeBytes   = ADDR_WIDTH'(1) << size_q;
    alignedAddr = addr_q & ~(sizeBytes - ADDR_WIDTH'(1));
    incrAddr    = alignedAddr + sizeBytes;
    wrapMask    = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      2'b00:   nextAddr = addr_q;
      2'b10:   nextAddr = (addr_q & ~wrapMask) | (incrAddr & wrapMask);
      default: nextAddr = incrAddr;
    endcase
  end

  // Burst FSM: pick the next state and the registered handshake readies
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (awHs) state_d = DATA;
      DATA:    if (wHs && lastBeat) state_d = RESP;
      RESP:    if (bHs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  // Capture the burst context on AW, then for each W beat step the address and
  // build the memory write and the error flags
  always_comb begin
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    size_d     = size_q;
    burst_d    = burst_q;
    cfgErr_d   = cfgErr_q;
    slvErr_d   = slvErr_q;
    decErr_d   = decErr_q;
    bresp_d    = bresp_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWstrb_d = memWstrb_q;

    if (awHs) begin
      id_d     = bus.awid;
      addr_d   = bus.awaddr;
      len_d    = bus.awlen;
      size_d   = bus.awsize;
      burst_d  = bus.awburst;
      beat_d   = 8'd0;
      cfgErr_d = cfgErrAw;
      slvErr_d = cfgErrAw;
      decErr_d = 1'b0;
    end

    if (wHs) begin
      addr_d     = nextAddr;
      beat_d     = beat_q + 8'd1;
      memAddr_d  = addr_q[OFF_W +: IDX_W];
      memWdata_d = bus.wdata;
      memWstrb_d = bus.wstrb;
      memWe_d    = !(cfgErr_q | widErr | outOfRange | wlastKill);
      slvErr_d   = slvErr_q | widErr | wlastMis;
      decErr_d   = decErr_q | outOfRange;
      if (lastBeat) begin
        bresp_d = slvErr_d ? 2'b10 : (decErr_d ? 2'b11 : 2'b00);
      end
    end
  end

  // State register and registered handshake readies
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Burst context, error flags, response code and memory port registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      cfgErr_q   <= 1'b0;
      slvErr_q   <= 1'b0;
      decErr_q   <= 1'b0;
      bresp_q    <= 2'b00;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWstrb_q <= '0;
    end else begin
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      cfgErr_q   <= cfgErr_d;
      slvErr_q   <= slvErr_d;
      decErr_q   <= decErr_d;
      bresp_q    <= bresp_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWstrb_q <= memWstrb_d;
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bid     = id_q;
  assign bus.bresp   = bresp_q;

  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;
  assign mem_wstrb_o = memWstrb_q;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave.
// A table of directed bursts is driven through the master side. Each row is
// checked for the memory writes it produces and for its B response. Separate
// hand-written sequences cover reset values, a stalled B channel, and a reset
// that arrives in the middle of a burst.
module tb_axi_wr_slave;

  typedef struct {
    string       name;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          widBad;
    logic [31:0] dataBase;
    logic [3:0]  weMask;
    logic [3:0][7:0] expIdx;
    logic [1:0]  expResp;
  } vec_t;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        memWe;
  logic [7:0]  memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memWstrb;

  int testsRun = 0;
  int failures = 0;
  wr_t  memQ[$];
  vec_t vecs[11];

  always #5 aclk = ~aclk;

  axi_wr_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8)) bus ();

  axi_wr_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ID_WIDTH(8),
    .MEM_DEPTH(256)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus),
    .mem_we_o(memWe),
    .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata),
    .mem_wstrb_o(memWstrb)
  );

  // Record every memory write the DUT issues, sampled mid-cycle
  always @(negedge aclk) begin
    if (memWe) memQ.push_back('{idx: memAddr, data: memWdata, strb: memWstrb});
  end

  // Stop a run that hangs
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic [7:0] id, input logic [31:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                              input int widBad, input logic [31:0] dataBase, input logic [3:0] weMask,
                              input logic [7:0] i0, input logic [7:0] i1, input logic [7:0] i2,
                              input logic [7:0] i3, input logic [1:0] resp);
    vec_t v;
    v.name = n; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.widBad = widBad; v.dataBase = dataBase; v.weMask = weMask;
    v.expIdx[0] = i0; v.expIdx[1] = i1; v.expIdx[2] = i2; v.expIdx[3] = i3;
    v.expResp = resp;
    return v;
  endfunction

  task automatic sendAw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    @(negedge aclk);
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    while (!bus.awready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("awready_wait", 32'(bus.awready), 32'd1);
    @(posedge aclk);
    #1 bus.awvalid = 1'b0;
  endtask

  task automatic sendBeat(input logic [7:0] wid, input logic [31:0] data, input logic [3:0] strb,
                          input logic last);
    int n = 0;
    @(negedge aclk);
    bus.wid = wid; bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
    while (!bus.wready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("wready_wait", 32'(bus.wready), 32'd1);
    @(posedge aclk);
    #1 bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
  endtask

  // Drive one full burst with bready high and compare writes and response
  task automatic applyStimulus(input vec_t v);
    int n = 0;
    wr_t w;
    memQ.delete();
    bus.bready = 1'b1;
    sendAw(v.id, v.addr, v.len, v.size, v.burst);
    for (int b = 0; b <= int'(v.len); b++) begin
      sendBeat((b == v.widBad) ? ~v.id : v.id, v.dataBase + 32'(b), 4'hF >> b, b == int'(v.len));
    end
    @(negedge aclk);
    checkOutput({v.name, "_bvalid_after_last"}, 32'(bus.bvalid), 32'd1);
    checkOutput({v.name, "_wready_after_last"}, 32'(bus.wready), 32'd0);
    while (!bus.bvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    checkOutput({v.name, "_bresp"}, 32'(bus.bresp), 32'(v.expResp));
    checkOutput({v.name, "_bid"}, 32'(bus.bid), 32'(v.id));
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checkOutput({v.name, "_bvalid_after_b"}, 32'(bus.bvalid), 32'd0);
    checkOutput({v.name, "_awready_after_b"}, 32'(bus.awready), 32'd1);
    checkOutput({v.name, "_write_count"}, 32'(memQ.size()), 32'($countones(v.weMask)));
    for (int b = 0; b <= int'(v.len); b++) begin
      if (v.weMask[b] && memQ.size() > 0) begin
        w = memQ.pop_front();
        checkOutput($sformatf("%s_idx%0d", v.name, b), 32'(w.idx), 32'(v.expIdx[b]));
        checkOutput($sformatf("%s_data%0d", v.name, b), w.data, v.dataBase + 32'(b));
        checkOutput($sformatf("%s_strb%0d", v.name, b), 32'(w.strb), 32'(4'hF >> b));
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_awready"}, 32'(bus.awready), 32'd0);
    checkOutput({tag, "_wready"}, 32'(bus.wready), 32'd0);
    checkOutput({tag, "_bvalid"}, 32'(bus.bvalid), 32'd0);
    checkOutput({tag, "_bid"}, 32'(bus.bid), 32'd0);
    checkOutput({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(memWe), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, memWdata, 32'd0);
    checkOutput({tag, "_mem_wstrb"}, 32'(memWstrb), 32'd0);
  endtask

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;

    vecs[0]  = mk("incr",     8'h5A, 32'h10,  8'd3, 3'd2, 2'b01, -1, 32'h1,   4'b1111,  8'd4,  8'd5,  8'd6,  8'd7, 2'b00);
    vecs[1]  = mk("wrap4",    8'h11, 32'h38,  8'd3, 3'd2, 2'b10, -1, 32'hA0,  4'b1111, 8'd14, 8'd15, 8'd12, 8'd13, 2'b00);
    vecs[2]  = mk("rsvd",     8'h22, 32'h0,   8'd1, 3'd2, 2'b11, -1, 32'hB0,  4'b0000,  8'd0,  8'd0,  8'd0,  8'd0, 2'b10);
    vecs[3]  = mk("decode",   8'h33, 32'h3FC, 8'd1, 3'd2, 2'b01, -1, 32'hC0,  4'b0001, 8'd255, 8'd0, 8'd0,  8'd0, 2'b11);
    vecs[4]  = mk("fixed",    8'h44, 32'h20,  8'd2, 3'd2, 2'b00, -1, 32'hD0,  4'b0111,  8'd8,  8'd8,  8'd8,  8'd0, 2'b00);
    vecs[5]  = mk("widbad",   8'h55, 32'h40,  8'd2, 3'd2, 2'b01,  1, 32'hE0,  4'b0101, 8'd16, 8'd17, 8'd18,  8'd0, 2'b10);
    vecs[6]  = mk("oversize", 8'h66, 32'h0,   8'd0, 3'd3, 2'b01, -1, 32'hF0,  4'b0000,  8'd0,  8'd0,  8'd0,  8'd0, 2'b10);
    vecs[7]  = mk("wraplen",  8'h77, 32'h0,   8'd2, 3'd2, 2'b10, -1, 32'h100, 4'b0000,  8'd0,  8'd0,  8'd0,  8'd0, 2'b10);
    vecs[8]  = mk("narrow",   8'h88, 32'h81,  8'd3, 3'd0, 2'b01, -1, 32'h110, 4'b1111, 8'd32, 8'd32, 8'd32, 8'd33, 2'b00);
    vecs[9]  = mk("unalign",  8'h99, 32'h12,  8'd1, 3'd2, 2'b01, -1, 32'h120, 4'b0011,  8'd4,  8'd5,  8'd0,  8'd0, 2'b00);
    vecs[10] = mk("wrap2",    8'hAA, 32'h1C,  8'd1, 3'd2, 2'b10, -1, 32'h130, 4'b0011,  8'd7,  8'd6,  8'd0,  8'd0, 2'b00);

    // Reset state, then awready rising on the first edge after release
    repeat (3) @(negedge aclk);
    checkResetValues("reset");
    aresetn = 1'b1;
    #1 checkOutput("awready_before_edge", 32'(bus.awready), 32'd0);
    @(posedge aclk);
    #1 checkOutput("awready_first_edge", 32'(bus.awready), 32'd1);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // B channel stalled for five cycles: the response must hold steady
    memQ.delete();
    bus.bready = 1'b0;
    sendAw(8'hC3, 32'h100, 8'd1, 3'd2, 2'b01);
    sendBeat(8'hC3, 32'h200, 4'hF, 1'b0);
    sendBeat(8'hC3, 32'h201, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      checkOutput($sformatf("stall%0d_bvalid", c), 32'(bus.bvalid), 32'd1);
      checkOutput($sformatf("stall%0d_bresp", c), 32'(bus.bresp), 32'd0);
      checkOutput($sformatf("stall%0d_bid", c), 32'(bus.bid), 32'hC3);
      checkOutput($sformatf("stall%0d_awready", c), 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    checkOutput("stall_bvalid_after_b", 32'(bus.bvalid), 32'd0);
    checkOutput("stall_awready_after_b", 32'(bus.awready), 32'd1);
    checkOutput("stall_write_count", 32'(memQ.size()), 32'd2);

    // Reset in the middle of a burst: no response, no more writes, then recover
    sendAw(8'h3C, 32'h0, 8'd3, 3'd2, 2'b01);
    sendBeat(8'h3C, 32'h300, 4'hF, 1'b0);
    sendBeat(8'h3C, 32'h301, 4'hF, 1'b0);
    @(negedge aclk);
    aresetn = 1'b0;
    bus.wid = 8'h3C; bus.wdata = 32'h302; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    #1 checkResetValues("midreset");
    memQ.delete();
    repeat (3) @(negedge aclk);
    bus.wvalid = 1'b0;
    aresetn = 1'b1;
    repeat (5) @(negedge aclk);
    checkOutput("midreset_no_writes", 32'(memQ.size()), 32'd0);
    checkOutput("midreset_no_bvalid", 32'(bus.bvalid), 32'd0);
    vecs[0].name = "after_reset";
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
